// File: rtl/k_fifo_pkg.sv
// Shared constants and pointer helpers for the k_sync_fifo_t2 family.
// Pointers are passed zero-extended to 32 bits so one helper serves every ADDR_W.
package k_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic logic ptr_empty(input logic [31:0] wptr, input logic [31:0] rptr);
        return wptr == rptr;
    endfunction

    // Full when the address bits match and only the wrap bit (bit addr_w) differs.
    function automatic logic ptr_full(input logic [31:0] wptr, input logic [31:0] rptr,
                                      input int addr_w);
        return (wptr ^ rptr) == (32'd1 << addr_w);
    endfunction

endpackage

// File: rtl/k_dp_ram_t2.sv
// Parametrised dual-port RAM: synchronous write, asynchronous read, no reset.
// Generalised successor of the 2-deep RAM used in the FIFO path.
module k_dp_ram_t2
    import k_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              wen_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wen_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/k_sync_fifo_t2.sv
// Single-clock show-ahead FIFO with count and almost-full/almost-empty flags.
// Define K_FIFO_ERR_EN to add sticky overflow/underflow error ports.
module k_sync_fifo_t2
    import k_fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int AF_LEVEL = depth_of(ADDR_W) - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count
`ifdef K_FIFO_ERR_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam int              PAD     = 31 - ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] AF_LVL  = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_LVL  = (ADDR_W+1)'(AE_LEVEL);

    logic [ADDR_W:0] wptr_q, wptr_d;
    logic [ADDR_W:0] rptr_q, rptr_d;
    logic            do_wr, do_rd;

    // Handshake: a request is accepted only when its enable is high and the
    // registered flag guarding it (full for writes, empty for reads) is low;
    // a refused request leaves pointers, count and memory untouched.
    assign empty = ptr_empty({{PAD{1'b0}}, wptr_q}, {{PAD{1'b0}}, rptr_q});
    assign full  = ptr_full({{PAD{1'b0}}, wptr_q}, {{PAD{1'b0}}, rptr_q}, ADDR_W);
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    assign count        = wptr_q - rptr_q;
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_wr) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (do_rd) begin
            rptr_d = rptr_q + PTR_ONE;
        end
    end

`ifdef K_FIFO_ERR_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q | (wr_en & full);
        unf_d = unf_q | (rd_en & empty);
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
`ifdef K_FIFO_ERR_EN
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
`endif
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
`ifdef K_FIFO_ERR_EN
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
`endif
        end
    end

    k_dp_ram_t2 #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk),
        .wen_i   (do_wr),
        .waddr_i (wptr_q[ADDR_W-1:0]),
        .wdata_i (wr_data),
        .raddr_i (rptr_q[ADDR_W-1:0]),
        .rdata_o (rd_data)
    );

endmodule

// File: tb/tb_k_sync_fifo_t2.sv
// Directed, table-driven bench for k_sync_fifo_t2 (DATA_W=8, ADDR_W=4, DEPTH=16).
// Covers the K_FIFO_ERR_EN error flags when that macro is defined.
module tb_k_sync_fifo_t2;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    typedef struct {
        logic             wr;
        logic             rd;
        logic [7:0]       wd;
        logic [ADDR_W:0]  cnt;
        logic             chk;
        logic [7:0]       head;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [DATA_W-1:0] rd_data;
    logic              full, empty, almost_full, almost_empty;
    logic [ADDR_W:0]   count;
`ifdef K_FIFO_ERR_EN
    logic              overflow, underflow;
`endif

    int n_cmp = 0;
    int n_err = 0;
    vec_t vec_q[$];

    always #5 clk = ~clk;

    k_sync_fifo_t2 #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
`ifdef K_FIFO_ERR_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Flags follow directly from the expected occupancy.
    task automatic check_flags(input string tag, input logic [ADDR_W:0] cnt);
        check({tag, ".count"}, 32'(count), 32'(cnt));
        check({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
        check({tag, ".full"},  32'(full),  32'(cnt == 16));
        check({tag, ".af"},    32'(almost_full),  32'(cnt >= 14));
        check({tag, ".ae"},    32'(almost_empty), 32'(cnt <= 2));
    endtask

    task automatic cycle(input logic wr, input logic rd, input logic [7:0] wd);
        @(negedge clk);
        wr_en   = wr;
        rd_en   = rd;
        wr_data = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    function automatic void add(input logic wr, input logic rd, input logic [7:0] wd,
                                input int cnt, input logic chk, input logic [7:0] head);
        vec_t v;
        v.wr = wr; v.rd = rd; v.wd = wd;
        v.cnt = (ADDR_W+1)'(cnt);
        v.chk = chk; v.head = head;
        vec_q.push_back(v);
    endfunction

    initial begin
        // Fill 0x00..0x0F: head stays 0x00, full on the 16th write.
        for (int k = 0; k < 16; k++) add(1'b1, 1'b0, 8'(k), k + 1, 1'b1, 8'h00);
        add(1'b1, 1'b0, 8'hEE, 16, 1'b1, 8'h00);           // 17th write ignored
        add(1'b1, 1'b1, 8'h77, 15, 1'b1, 8'h01);           // simultaneous at full
        for (int j = 0; j < 15; j++) add(1'b0, 1'b1, 8'h00, 14 - j, (j < 14), 8'(2 + j));
        add(1'b1, 1'b1, 8'h3C, 1, 1'b1, 8'h3C);            // simultaneous at empty
        add(1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h00);
        add(1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h00);            // read at empty ignored
        for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 8'(8'h40 + k), k + 1, 1'b1, 8'h40);
        for (int i = 0; i < 40; i++) add(1'b1, 1'b1, 8'(8'h43 + i), 3, 1'b1, 8'(8'h41 + i));
        add(1'b0, 1'b1, 8'h00, 2, 1'b1, 8'h69);
        add(1'b0, 1'b1, 8'h00, 1, 1'b1, 8'h6A);
        add(1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h00);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_flags("reset", 0);
`ifdef K_FIFO_ERR_EN
        check("reset.overflow", 32'(overflow), 32'd0);
        check("reset.underflow", 32'(underflow), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-traffic with five words held.
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 8'(8'h10 + k));
        check_flags("pre_rst", 5);
        check("pre_rst.head", 32'(rd_data), 32'h10);
        #2 rst_n = 1'b0;
        #1;
        check_flags("mid_rst", 0);
        idle();
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 8'hA5);
        check_flags("post_rst", 1);
        check("post_rst.head", 32'(rd_data), 32'hA5);
        cycle(1'b0, 1'b1, 8'h00);
        check_flags("post_rst_rd", 0);
        idle();

`ifdef K_FIFO_ERR_EN
        cycle(1'b0, 1'b1, 8'h00);
        check("err.underflow", 32'(underflow), 32'd1);
        check("err.no_overflow", 32'(overflow), 32'd0);
        for (int k = 0; k < 16; k++) cycle(1'b1, 1'b0, 8'(k));
        check("err.still_no_ovf", 32'(overflow), 32'd0);
        cycle(1'b1, 1'b0, 8'hFF);
        check("err.overflow", 32'(overflow), 32'd1);
        check_flags("err.full", 16);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b1, 8'h55);
        check("err.ovf_sticky", 32'(overflow), 32'd1);
        check("err.unf_sticky", 32'(underflow), 32'd1);
        check("err.head", 32'(rd_data), 32'h02);
        idle();
        rst_n = 1'b0;
        #1;
        check("err.ovf_clr", 32'(overflow), 32'd0);
        check("err.unf_clr", 32'(underflow), 32'd0);
        check_flags("err.rst", 0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        // Table-driven vectors.
        foreach (vec_q[i]) begin
            cycle(vec_q[i].wr, vec_q[i].rd, vec_q[i].wd);
            check_flags($sformatf("vec%0d", i), vec_q[i].cnt);
            if (vec_q[i].chk) begin
                check($sformatf("vec%0d.head", i), 32'(rd_data), 32'(vec_q[i].head));
            end
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/k_sync_fifo_t2.md
Name: k_sync_fifo_t2

Overview:
- Parametrised single-clock FIFO, successor to the 2-deep dual-port RAM used in the FIFO path.
- Storage depth is 2^ADDR_W with configurable data width.
- Adds pointer management, full/empty, occupancy count and almost-full/almost-empty thresholds.
- Show-ahead read: the head word is always presented on rd_data while the FIFO is not empty.

Parameters:
- DATA_W, 8: data word width in bits.
- ADDR_W, 4: address width; depth DEPTH = 2^ADDR_W (ADDR_W >= 1).
- AF_LEVEL, DEPTH-2: almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write request.
- wr_data  input  DATA_W  write word.
- rd_en  input  1  read (pop) request.
- rd_data  output  DATA_W  head word (show-ahead); valid only when empty=0.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky write-while-full error (K_FIFO_ERR_EN only).
- underflow  output  1  sticky read-while-empty error (K_FIFO_ERR_EN only).

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0:
  - wptr=rptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0 (AF_LEVEL>0).
  - overflow=underflow=0.
  - Memory contents are not reset; rd_data is don't-care while empty.
- Pointers are ADDR_W+1 bits; the MSB is the wrap bit.
  - empty = (wptr == rptr).
  - full = address bits equal and wrap bits differ.
  - count = wptr - rptr, modulo 2^(ADDR_W+1).
  - All flags are registered or derived only from registered pointers; no combinational path from wr_en/rd_en to any flag.
- Write accepted (do_wr) = wr_en & ~full.
  - On do_wr: mem[wptr[ADDR_W-1:0]] <= wr_data and wptr increments at the clock edge.
- Read accepted (do_rd) = rd_en & ~empty.
  - On do_rd: rptr increments at the clock edge.
  - rd_data = mem[rptr[ADDR_W-1:0]], combinational from the RAM.
- Latency:
  - A word written at edge N is visible on rd_data and empty falls after edge N (same-cycle visibility is not required).
  - Write-to-read minimum latency is 1 cycle.
- Simultaneous events:
  - do_wr & do_rd: both pointers advance and count is unchanged.
  - Full with wr_en & rd_en: only the read is accepted, because the write is gated by the registered full. Count decrements and full deasserts next cycle.
  - Empty with wr_en & rd_en: only the write is accepted. Count becomes 1.
- Wrap: pointers roll from 2^(ADDR_W+1)-1 to 0 with no special handling; full and empty stay correct across any number of wraps.
- Ignored requests never change pointers, count or memory.
- Reset mid-operation: state clears immediately on rst_n fall. The first accepted write after release lands at address 0.

Optional Feature:
- Macro: K_FIFO_ERR_EN.
- Defined:
  - overflow sets on wr_en & full; underflow sets on rd_en & empty.
  - Both flags are sticky until rst_n.
  - Neither flag affects data-path behaviour.
- Undefined: the overflow and underflow ports and their logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package k_fifo_pkg:
  - Default DATA_W/ADDR_W constants.
  - Function to compute depth from ADDR_W.
  - Pointer-compare helper functions for full and empty.
- Sub-module k_dp_ram_t2:
  - Parametrised DATA_W/ADDR_W dual-port RAM.
  - Synchronous write on clk when wen; asynchronous read; no reset.
  - It is the generalised successor of the existing 2-deep RAM, and the FIFO instantiates it once.

Test Plan:
- Reset: assert rst_n=0 mid-traffic with count=5 -> count=0, empty=1, full=0 immediately. After release, writing 0xA5 then reading gives 0xA5.
- Fill and drain (DEPTH=16): write 0x00..0x0F ->
  - full=1 at count=16; almost_full from count=14; a 17th write is ignored.
  - Draining returns 0x00..0x0F in order and empty=1 after the 16th read.
- Simultaneous on full: wr_en=rd_en=1 with count=16 -> count=15, head advances, and the written word is discarded.
- Simultaneous on empty: wr_en=rd_en=1 with count=0, wr_data=0x3C -> count=1, rd_data=0x3C next cycle.
- Wrap: 40 cycles of continuous write+read at steady count=3 -> data order preserved, count stays 3, no spurious full or empty.
- K_FIFO_ERR_EN: read at empty sets underflow=1; write at full sets overflow=1. Both stay set through later traffic until rst_n=0.
